// File: rtl/usb_byte_fifo_tx.sv
// Byte FIFO between the frame serializer and an FT245-style USB FIFO chip.
// Bytes are captured on WR rising edges and drained as timed USB_WR strobes gated by nTXE.
module usb_byte_fifo_tx #(
    parameter int ADDR_W   = 6,
    parameter int WR_PULSE = 3,
    parameter int GAP_CYC  = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        DIN,
    input  logic              WR,
    input  logic              nTXE,
    output logic [7:0]        USB_D,
    output logic              USB_WR,
    output logic [ADDR_W:0]   LEVEL,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVF
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (WR_PULSE > GAP_CYC) ? WR_PULSE : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [ADDR_W:0]  DEPTH_LVL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] rptr_q;
    logic [ADDR_W:0]   level_q;
    logic [ADDR_W:0]   level_d;
    logic              empty_q;
    logic              full_q;
    logic              ovf_q;
    logic              wr_dly_q;
    logic              txe_s1_q;
    logic              txe_s2_q;
    logic [7:0]        usb_d_q;
    logic              usb_wr_q;
    logic              usb_wr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    state_t            state_q;
    state_t            state_d;

    logic push;
    logic push_ok;
    logic drop;
    logic pop;
    logic txe_ok;

    assign push    = WR & ~wr_dly_q;
    // FULL is judged before any same-cycle pop, so a full FIFO never accepts a byte
    assign push_ok = push & ~full_q;
    assign drop    = push & full_q;
    assign txe_ok  = ~txe_s2_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_dly_q <= 1'b1;
            txe_s1_q <= 1'b1;
            txe_s2_q <= 1'b1;
        end else begin
            wr_dly_q <= WR;
            txe_s1_q <= nTXE;
            txe_s2_q <= txe_s1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wptr_q] <= DIN;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == DEPTH_LVL);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        usb_wr_d = usb_wr_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                usb_wr_d = 1'b0;
                if (!empty_q && txe_ok) begin
                    pop      = 1'b1;
                    usb_wr_d = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    usb_wr_d = 1'b0;
                    cnt_d    = GAP_LOAD;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                // nTXE is deliberately ignored here; it is only sampled again in IDLE
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                usb_wr_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            usb_wr_q <= 1'b0;
            usb_d_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            usb_wr_q <= usb_wr_d;
            if (pop) begin
                usb_d_q <= mem_q[rptr_q];
            end
        end
    end

    assign USB_D  = usb_d_q;
    assign USB_WR = usb_wr_q;
    assign LEVEL  = level_q;
    assign EMPTY  = empty_q;
    assign FULL   = full_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_usb_byte_fifo_tx.sv
// Bench for usb_byte_fifo_tx: directed frames plus randomized traffic against a queue-based model.
// The model keeps the byte queue and strobe timing rules; a per-cycle process compares all outputs.
module tb_usb_byte_fifo_tx;

    localparam int ADDR_W = 6;
    localparam int P      = 3;
    localparam int G      = 2;
    localparam int DEPTH  = 64;

    logic        CLK   = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  DIN   = 8'h00;
    logic        WR    = 1'b0;
    logic        nTXE  = 1'b1;
    logic [7:0]  USB_D;
    logic        USB_WR;
    logic [ADDR_W:0] LEVEL;
    logic        EMPTY;
    logic        FULL;
    logic        OVF;

    usb_byte_fifo_tx #(.ADDR_W(ADDR_W), .WR_PULSE(P), .GAP_CYC(G)) dut (
        .CLK(CLK), .Reset(Reset), .DIN(DIN), .WR(WR), .nTXE(nTXE),
        .USB_D(USB_D), .USB_WR(USB_WR), .LEVEL(LEVEL),
        .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [7:0] q[$];
    logic [7:0] seen[$];
    logic       m_prev_wr = 1'b1;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_ovf = 1'b0;
    logic       m_have_r = 1'b0;
    logic       m_wr = 1'b0;
    logic [7:0] m_d = 8'h00;
    int         cyc = 0;
    int         last_r = 0;
    logic       prev_usb_wr = 1'b0;
    int         hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;

    always @(posedge CLK) begin
        logic txe_ok, push, acc, rise;
        int   sz;
        cyc++;
        if (Reset) begin
            q.delete();
            m_prev_wr = 1'b1;
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            m_ovf = 1'b0;
            m_have_r = 1'b0;
            m_d = 8'h00;
        end else begin
            txe_ok = !m_s2;
            m_s2 = m_s1;
            m_s1 = nTXE;
            push = WR && !m_prev_wr;
            m_prev_wr = WR;
            sz = q.size();
            rise = (!m_have_r || (cyc - last_r) >= P + G + 1) && (sz > 0) && txe_ok;
            acc = push && (sz < DEPTH);
            if (push && !acc) m_ovf = 1'b1;
            if (rise) begin
                m_d = q.pop_front();
                last_r = cyc;
                m_have_r = 1'b1;
            end
            if (acc) q.push_back(DIN);
        end
        m_wr = m_have_r && ((cyc - last_r) < P);
        #1;
        chk("usb_wr", USB_WR, m_wr);
        chk("usb_d", USB_D, m_d);
        chk("level", LEVEL, q.size());
        chk("empty", EMPTY, q.size() == 0);
        chk("full", FULL, q.size() == DEPTH);
        chk("ovf", OVF, m_ovf);
        if (USB_WR) begin
            if (!prev_usb_wr) begin
                seen.push_back(USB_D);
                $display("strobe byte 0x%02h level %0d", USB_D, LEVEL);
                last_lo = lo_run;
                hi_run = 1;
            end else begin
                hi_run++;
            end
        end else begin
            if (prev_usb_wr) begin
                last_hi = hi_run;
                lo_run = 1;
            end else begin
                lo_run++;
            end
        end
        prev_usb_wr = USB_WR;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge CLK);
        DIN = b;
        WR  = 1'b1;
        @(negedge CLK);
        WR  = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (LEVEL == 0 && !USB_WR) break;
        end
        if (k == budget) chk("drain_timeout", 0, 1);
        idle(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        @(posedge CLK);
        #2;
        chk("rst_usb_wr", USB_WR, 0);
        chk("rst_usb_d", USB_D, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVF, 0);
        idle(2);
        Reset = 1'b0;

        // Two bytes, immediate drain
        nTXE = 1'b0;
        idle(4);
        seen.delete();
        push_byte(8'hAA);
        push_byte(8'h11);
        wait_drained(500);
        chk("t1_count", seen.size(), 2);
        chk("t1_b0", seen[0], 8'hAA);
        chk("t1_b1", seen[1], 8'h11);
        chk("t1_high_len", last_hi, 3);
        chk("t1_low_len", last_lo, 3);
        chk("t1_level", LEVEL, 0);
        chk("t1_empty", EMPTY, 1);
        chk("t1_ovf", OVF, 0);

        // Frame buffered while USB chip is full, then released
        nTXE = 1'b1;
        idle(4);
        seen.delete();
        push_byte(8'hAA);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        idle(2);
        chk("t2_level", LEVEL, 17);
        chk("t2_no_strobe", seen.size(), 0);
        @(negedge CLK);
        nTXE = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (USB_WR) break;
        end
        chk("t2_first_latency", k, 3);
        wait_drained(1000);
        chk("t2_count", seen.size(), 17);
        for (int i = 0; i < 17; i++) chk("t2_byte", seen[i], (i == 0) ? 8'hAA : 8'(i - 1));

        // Overflow
        nTXE = 1'b1;
        idle(4);
        seen.delete();
        for (int i = 0; i < 70; i++) push_byte(8'(i));
        idle(2);
        chk("t3_level", LEVEL, 64);
        chk("t3_full", FULL, 1);
        chk("t3_ovf", OVF, 1);
        nTXE = 1'b0;
        wait_drained(2000);
        chk("t3_count", seen.size(), 64);
        for (int i = 0; i < 64; i++) chk("t3_byte", seen[i], 8'(i));

        // Randomized traffic with nTXE toggling, across pointer wrap
        nTXE = 1'b0;
        seen.delete();
        for (int n = 0; n < 150; n++) begin
            push_byte(8'($urandom));
            idle($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) nTXE = ~nTXE;
        end
        nTXE = 1'b0;
        wait_drained(3000);
        chk("t4_level", LEVEL, 0);

        // Push and pop in the same cycle while full
        nTXE = 1'b1;
        idle(4);
        seen.delete();
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        idle(2);
        chk("t6_full", FULL, 1);
        @(negedge CLK);
        nTXE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("t6_level_before", LEVEL, 64);
        DIN = 8'hEE;
        WR  = 1'b1;
        @(negedge CLK);
        WR  = 1'b0;
        chk("t6_level_after", LEVEL, 63);
        chk("t6_usb_wr", USB_WR, 1);
        chk("t6_ovf", OVF, 1);
        wait_drained(2000);
        chk("t6_count", seen.size(), 64);
        for (int i = 0; i < 64; i++) chk("t6_byte", seen[i], 8'(i));

        // Asynchronous reset during a strobe, WR held high through release
        nTXE = 1'b0;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        for (k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (USB_WR) break;
        end
        chk("t5_strobe_seen", USB_WR, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_usb_wr_async", USB_WR, 0);
        chk("t5_level_async", LEVEL, 0);
        chk("t5_ovf_async", OVF, 0);
        chk("t5_empty_async", EMPTY, 1);
        DIN = 8'h55;
        WR  = 1'b1;
        idle(2);
        Reset = 1'b0;
        idle(4);
        chk("t5_level_wr_held", LEVEL, 0);
        WR = 1'b0;
        idle(10);
        chk("t5_usb_wr_final", USB_WR, 0);
        chk("t5_empty_final", EMPTY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
